spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Shares the single-port command interface of `ram` between N_REQ requesters, e.g. the SPI slave plus a local host/BIST engine.
- Each requester issues 10-bit command words {cmd[1:0], payload[7:0]}:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data
- Arbitration is round-robin. Grant is locked for a whole transaction: write = 00 then 01; read = 10, 11, then tx_valid response.
- Read data is routed back to the owning requester only.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- IDW, $clog2(N_REQ) (min 1), width of owner/err id.
- TIMEOUT, 64, lock-timeout cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  command valid per requester.
- req_data  in  N_REQ x 10  command word per requester.
- req_ready  out  N_REQ  command accepted this cycle (valid & ready).
- rsp_valid  out  N_REQ  one-cycle read-data pulse to the owner.
- rsp_data  out  8  read data; valid only with rsp_valid.
- ram_din  out  10  command word to ram.
- ram_rx_valid  out  1  command strobe to ram.
- ram_tx_data  in  8  read data from ram.
- ram_tx_valid  in  1  read data valid from ram.
- busy  out  1  grant locked (state != IDLE).
- owner_id  out  IDW  current owner; 0 when idle.
- err_valid  out  1  one-cycle protocol-error pulse.
- err_id  out  IDW  requester that caused the error.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 highest priority).
- Handshake:
  - req_ready is combinational from state, owner and pointer.
  - A requester holds req_valid/req_data stable until ready.
  - At most one requester is ready per cycle.
- Forwarding: an accepted legal word appears on ram_din with ram_rx_valid=1 exactly one cycle later (registered). ram_rx_valid is otherwise 0.
- State IDLE:
  - Pick the first valid requester at or after the pointer, circularly; it is ready this cycle.
  - cmd 00 -> forward, owner=winner, go LOCK_WR.
  - cmd 10 -> forward, owner=winner, go LOCK_RD.
  - cmd 01/11 -> accept and drop, err pulse with err_id=winner, stay IDLE, advance pointer past winner.
- State LOCK_WR (only owner ready):
  - 00 -> forward, stay (address rewrite).
  - 01 -> forward, release.
  - 10/11 -> accept, drop, err pulse, stay.
- State LOCK_RD (only owner ready):
  - 10 -> forward, stay.
  - 11 -> forward, go WAIT_RSP.
  - 00/01 -> accept, drop, err pulse, stay.
- State WAIT_RSP:
  - No requester ready.
  - On ram_tx_valid: next cycle rsp_valid[owner]=1 and rsp_data=ram_tx_data, then release.
- Release: state IDLE, pointer = owner+1 mod N_REQ, owner_id=0. A new grant is possible the cycle after release.
- Simultaneous valids in IDLE: the pointer decides; losers see ready=0 with no side effect.
- ram_tx_valid outside WAIT_RSP is ignored; no rsp and no err.
- Non-owner requests during a lock stay pending; they are never dropped.
- Asynchronous reset mid-transaction aborts immediately. No rsp is produced; the ram keeps its own state.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in LOCK_WR, LOCK_RD or WAIT_RSP. It resets on every accepted owner word.
  - On reaching TIMEOUT-1: force release, err pulse with err_id=owner, and no rsp.
  - A ram_tx_valid arriving after a timeout is ignored.
- Undefined: no counter; the lock is held indefinitely.

Decomposition:
- Package spi_ram_arb_pkg:
  - enum ram_cmd_e {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}
  - enum arb_state_e {IDLE, LOCK_WR, LOCK_RD, WAIT_RSP}
  - CMD_W=2, PAYLOAD_W=8, WORD_W=10
- Sub-module rr_picker: combinational round-robin selector taking (valid vector, pointer) and returning one-hot grant plus index.

Test Plan:
- Write: req0 sends 0x000 then 0x1A5 -> ram_din 0x000 then 0x1A5, each one cycle after accept; busy high between the two words; pointer -> 1.
- Read: req1 sends 0x203 then 0x300; ram returns 0x5C -> rsp_valid=2'b10, rsp_data 0x5C one cycle after tx_valid; rsp_valid[0] stays 0.
- Contention: both valid in IDLE with pointer=0 -> req0 wins; req1 held during the lock and wins right after release; alternation continues over 8 transactions.
- Protocol error: req0 sends 0x1FF in IDLE -> accepted, no ram_rx_valid, err_valid=1 with err_id=0. In LOCK_WR, owner sends 0x2xx -> err, state unchanged.
- Reset: assert rst_n=0 in WAIT_RSP -> all outputs 0 asynchronously; after release, a fresh write from req1 completes normally.
- With ARB_TIMEOUT_EN: req0 sends 0x010 then stalls for 64 cycles -> err_id=0 pulse, busy drops, req1 granted next cycle.

Source files
------------

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and widths for the SPI/host RAM command arbiter.
// Command words are {cmd[1:0], payload[7:0]}; the arbiter never looks at the payload.
package spi_ram_arb_pkg;

   localparam int CMD_W     = 2;
   localparam int PAYLOAD_W = 8;
   localparam int WORD_W    = 10;

   typedef enum logic [CMD_W-1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } ram_cmd_e;

   typedef enum logic [1:0] {
      IDLE,
      LOCK_WR,
      LOCK_RD,
      WAIT_RSP
   } arb_state_e;

   // Circular successor of a requester index.
   function automatic int nextIdx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of requester-side and ram-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface spi_ram_arbiter_if
   import spi_ram_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

   logic [N_REQ-1:0]              req_valid;
   logic [N_REQ-1:0][WORD_W-1:0]  req_data;
   logic [N_REQ-1:0]              req_ready;
   logic [N_REQ-1:0]              rsp_valid;
   logic [PAYLOAD_W-1:0]          rsp_data;
   logic [WORD_W-1:0]             ram_din;
   logic                          ram_rx_valid;
   logic [PAYLOAD_W-1:0]          ram_tx_data;
   logic                          ram_tx_valid;
   logic                          busy;
   logic [IDW-1:0]                owner_id;
   logic                          err_valid;
   logic [IDW-1:0]                err_id;

   modport slave (
      input  req_valid, req_data, ram_tx_data, ram_tx_valid,
      output req_ready, rsp_valid, rsp_data, ram_din, ram_rx_valid,
             busy, owner_id, err_valid, err_id
   );

   modport master (
      output req_valid, req_data, ram_tx_data, ram_tx_valid,
      input  req_ready, rsp_valid, rsp_data, ram_din, ram_rx_valid,
             busy, owner_id, err_valid, err_id
   );

endinterface

// File: rtl/spi_ram_arbiter_rr_picker.sv
// Combinational round-robin selector: first valid requester at or after
// the pointer, searched circularly. Returns one-hot grant and its index.
module rr_picker #(
   parameter int N_REQ = 2,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDW-1:0]   idx_o,
   output logic             any_o
);

   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IDW'((int'(ptr_i) + i) % N_REQ);
         if (!found && valid_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            idx_o          = cand;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing the ram command port between N_REQ requesters,
// locking the grant per write/read transaction. Define ARB_TIMEOUT_EN for lock timeout.
module spi_ram_arbiter
   import spi_ram_arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_ram_arbiter_if.slave  bus
);

   if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 2) begin : gParamCheck
      $error("spi_ram_arbiter: N_REQ must be 2..4 and TIMEOUT at least 2");
   end

   arb_state_e           state_q, state_d;
   logic [IDW-1:0]       owner_q, owner_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [WORD_W-1:0]    ramDin_q, ramDin_d;
   logic                 ramRxValid_q, ramRxValid_d;
   logic [N_REQ-1:0]     rspValid_q, rspValid_d;
   logic [PAYLOAD_W-1:0] rspData_q, rspData_d;
   logic                 errValid_q, errValid_d;
   logic [IDW-1:0]       errId_q, errId_d;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 timeoutHit;
`endif

   logic [N_REQ-1:0]     pickGrant;
   logic [IDW-1:0]       pickIdx;
   logic                 pickAny;
   logic [N_REQ-1:0]     ownerMask;
   logic [N_REQ-1:0]     readyRaw;
   logic                 accept;
   logic [IDW-1:0]       accIdx;
   logic [WORD_W-1:0]    accWord;
   ram_cmd_e             accCmd;

   rr_picker #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) uPicker (
      .valid_i (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (pickGrant),
      .idx_o   (pickIdx),
      .any_o   (pickAny)
   );

   assign ownerMask = N_REQ'(1) << owner_q;

   always_comb begin
      readyRaw = '0;
      case (state_q)
         IDLE:             readyRaw = pickAny ? pickGrant : '0;
         LOCK_WR, LOCK_RD: readyRaw = bus.req_valid & ownerMask;
         default:          readyRaw = '0;
      endcase
   end

   // Ready is masked during reset so no requester believes a word was taken.
   assign bus.req_ready = readyRaw & {N_REQ{rst_n}};
   assign accept        = |readyRaw;
   assign accIdx        = (state_q == IDLE) ? pickIdx : owner_q;
   assign accWord       = bus.req_data[accIdx];
   assign accCmd        = ram_cmd_e'(accWord[WORD_W-1:PAYLOAD_W]);

`ifdef ARB_TIMEOUT_EN
   assign timeoutHit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      ptr_d        = ptr_q;
      ramDin_d     = ramDin_q;
      ramRxValid_d = 1'b0;
      rspValid_d   = '0;
      rspData_d    = rspData_q;
      errValid_d   = 1'b0;
      errId_d      = errId_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d        = (state_q == IDLE || accept) ? '0 : cnt_q + 1'b1;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (accCmd)
                  CMD_WR_ADDR: begin
                     ramDin_d     = accWord;
                     ramRxValid_d = 1'b1;
                     owner_d      = pickIdx;
                     state_d      = LOCK_WR;
                  end
                  CMD_RD_ADDR: begin
                     ramDin_d     = accWord;
                     ramRxValid_d = 1'b1;
                     owner_d      = pickIdx;
                     state_d      = LOCK_RD;
                  end
                  default: begin
                     // Stray data word with no lock: drop it and let the next requester in.
                     errValid_d = 1'b1;
                     errId_d    = pickIdx;
                     ptr_d      = IDW'(nextIdx(int'(pickIdx), N_REQ));
                  end
               endcase
            end
         end
         LOCK_WR: begin
            if (accept) begin
               case (accCmd)
                  CMD_WR_ADDR: begin
                     ramDin_d     = accWord;
                     ramRxValid_d = 1'b1;
                  end
                  CMD_WR_DATA: begin
                     ramDin_d     = accWord;
                     ramRxValid_d = 1'b1;
                     state_d      = IDLE;
                     owner_d      = '0;
                     ptr_d        = IDW'(nextIdx(int'(owner_q), N_REQ));
                  end
                  default: begin
                     errValid_d = 1'b1;
                     errId_d    = owner_q;
                  end
               endcase
            end
         end
         LOCK_RD: begin
            if (accept) begin
               case (accCmd)
                  CMD_RD_ADDR: begin
                     ramDin_d     = accWord;
                     ramRxValid_d = 1'b1;
                  end
                  CMD_RD_DATA: begin
                     ramDin_d     = accWord;
                     ramRxValid_d = 1'b1;
                     state_d      = WAIT_RSP;
                  end
                  default: begin
                     errValid_d = 1'b1;
                     errId_d    = owner_q;
                  end
               endcase
            end
         end
         WAIT_RSP: begin
            if (bus.ram_tx_valid) begin
               rspValid_d = ownerMask;
               rspData_d  = bus.ram_tx_data;
               state_d    = IDLE;
               owner_d    = '0;
               ptr_d      = IDW'(nextIdx(int'(owner_q), N_REQ));
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef ARB_TIMEOUT_EN
      // A stalled owner loses the lock; a real response in the same cycle still wins.
      if (timeoutHit && !accept && !(state_q == WAIT_RSP && bus.ram_tx_valid)) begin
         state_d    = IDLE;
         owner_d    = '0;
         ptr_d      = IDW'(nextIdx(int'(owner_q), N_REQ));
         errValid_d = 1'b1;
         errId_d    = owner_q;
         cnt_d      = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         ptr_q        <= '0;
         ramDin_q     <= '0;
         ramRxValid_q <= 1'b0;
         rspValid_q   <= '0;
         rspData_q    <= '0;
         errValid_q   <= 1'b0;
         errId_q      <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         ptr_q        <= ptr_d;
         ramDin_q     <= ramDin_d;
         ramRxValid_q <= ramRxValid_d;
         rspValid_q   <= rspValid_d;
         rspData_q    <= rspData_d;
         errValid_q   <= errValid_d;
         errId_q      <= errId_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign bus.ram_din      = ramDin_q;
   assign bus.ram_rx_valid = ramRxValid_q;
   assign bus.rsp_valid    = rspValid_q;
   assign bus.rsp_data     = rspData_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.owner_id     = owner_q;
   assign bus.err_valid    = errValid_q;
   assign bus.err_id       = errId_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with two requesters and hand-computed expectations.
// The lock-timeout scenario is compiled in only when ARB_TIMEOUT_EN is defined.
module tb_spi_ram_arbiter;

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;

   spi_ram_arbiter_if #(.N_REQ(2)) bus ();

   spi_ram_arbiter #(
      .N_REQ   (2),
      .TIMEOUT (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns 1 time unit after the rising edge, once everything has settled.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int r, input logic [9:0] w);
      bus.req_valid[r] = 1'b1;
      bus.req_data[r]  = w;
   endtask

   // Hold a word until the arbiter takes it, then drop valid; ends just after the accepting edge.
   task automatic sendWord(input int r, input logic [9:0] w, input string tag);
      int n;
      n = 0;
      applyStimulus(r, w);
      #1;
      while (!bus.req_ready[r] && n < 200) begin
         stepClk();
         n++;
      end
      checkOutput({tag, "_ready"}, 32'(bus.req_ready[r]), 32'd1);
      stepClk();
      bus.req_valid[r] = 1'b0;
   endtask

   initial begin
      testsRun        = 0;
      testsFailed     = 0;
      rst_n           = 1'b0;
      bus.req_valid   = 2'b01;
      bus.req_data    = '0;
      bus.ram_tx_data = 8'h00;
      bus.ram_tx_valid = 1'b0;

      // Reset state
      #3;
      checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rst_rxv", 32'(bus.ram_rx_valid), 32'h0);
      checkOutput("rst_din", 32'(bus.ram_din), 32'h0);
      checkOutput("rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("rst_owner", 32'(bus.owner_id), 32'h0);
      checkOutput("rst_err", 32'(bus.err_valid), 32'h0);
      checkOutput("rst_rsp", 32'(bus.rsp_valid), 32'h0);
      bus.req_valid = 2'b00;
      #9;
      rst_n = 1'b1;
      stepClk();

      // Write transaction from req0
      sendWord(0, 10'h000, "wr_addr");
      checkOutput("wr_addr_rxv", 32'(bus.ram_rx_valid), 32'h1);
      checkOutput("wr_addr_din", 32'(bus.ram_din), 32'h000);
      checkOutput("wr_addr_busy", 32'(bus.busy), 32'h1);
      checkOutput("wr_addr_owner", 32'(bus.owner_id), 32'h0);
      stepClk();
      checkOutput("wr_gap_rxv", 32'(bus.ram_rx_valid), 32'h0);
      checkOutput("wr_gap_busy", 32'(bus.busy), 32'h1);
      sendWord(0, 10'h1A5, "wr_data");
      checkOutput("wr_data_rxv", 32'(bus.ram_rx_valid), 32'h1);
      checkOutput("wr_data_din", 32'(bus.ram_din), 32'h1A5);
      checkOutput("wr_data_busy", 32'(bus.busy), 32'h0);
      bus.req_valid = 2'b11;
      bus.req_data  = {10'h000, 10'h000};
      #1;
      checkOutput("ptr_after_wr", 32'(bus.req_ready), 32'h2);
      bus.req_valid = 2'b00;

      // Read transaction from req1
      sendWord(1, 10'h203, "rd_addr");
      checkOutput("rd_addr_din", 32'(bus.ram_din), 32'h203);
      checkOutput("rd_addr_owner", 32'(bus.owner_id), 32'h1);
      sendWord(1, 10'h300, "rd_data");
      checkOutput("rd_data_din", 32'(bus.ram_din), 32'h300);
      checkOutput("rd_data_busy", 32'(bus.busy), 32'h1);
      applyStimulus(0, 10'h000);
      #1;
      checkOutput("wait_no_ready", 32'(bus.req_ready), 32'h0);
      bus.req_valid[0] = 1'b0;
      bus.ram_tx_data  = 8'h5C;
      bus.ram_tx_valid = 1'b1;
      stepClk();
      bus.ram_tx_valid = 1'b0;
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'h2);
      checkOutput("rsp_data", 32'(bus.rsp_data), 32'h5C);
      checkOutput("rsp_busy", 32'(bus.busy), 32'h0);
      checkOutput("rsp_owner", 32'(bus.owner_id), 32'h0);
      stepClk();
      checkOutput("rsp_pulse_end", 32'(bus.rsp_valid), 32'h0);

      // Response strobe while idle is ignored
      bus.ram_tx_data  = 8'h77;
      bus.ram_tx_valid = 1'b1;
      stepClk();
      bus.ram_tx_valid = 1'b0;
      checkOutput("idle_tx_rsp", 32'(bus.rsp_valid), 32'h0);
      checkOutput("idle_tx_err", 32'(bus.err_valid), 32'h0);

      // Contention: both requesters want write transactions; pointer is 0 so winners alternate 0,1,0,1...
      for (int t = 0; t < 8; t++) begin
         int w;
         logic [9:0] addrWord;
         logic [9:0] dataWord;
         w = t % 2;
         bus.req_valid   = 2'b11;
         bus.req_data[0] = {2'b00, 8'(t * 16)};
         bus.req_data[1] = {2'b00, 8'(t * 16 + 1)};
         addrWord        = {2'b00, 8'(t * 16 + w)};
         dataWord        = {2'b01, 8'(8'hD0 + t)};
         #1;
         checkOutput($sformatf("cont%0d_grant", t), 32'(bus.req_ready), (w == 0) ? 32'h1 : 32'h2);
         stepClk();
         checkOutput($sformatf("cont%0d_addr", t), 32'(bus.ram_din), 32'(addrWord));
         checkOutput($sformatf("cont%0d_owner", t), 32'(bus.owner_id), 32'(w));
         bus.req_data[w] = dataWord;
         #1;
         checkOutput($sformatf("cont%0d_lock", t), 32'(bus.req_ready), (w == 0) ? 32'h1 : 32'h2);
         stepClk();
         bus.req_valid[w] = 1'b0;
         checkOutput($sformatf("cont%0d_data", t), 32'(bus.ram_din), 32'(dataWord));
         checkOutput($sformatf("cont%0d_busy", t), 32'(bus.busy), 32'h0);
      end
      bus.req_valid = 2'b00;

      // Stray data word in IDLE
      sendWord(0, 10'h1FF, "err_idle");
      checkOutput("err_idle_rxv", 32'(bus.ram_rx_valid), 32'h0);
      checkOutput("err_idle_valid", 32'(bus.err_valid), 32'h1);
      checkOutput("err_idle_id", 32'(bus.err_id), 32'h0);
      checkOutput("err_idle_busy", 32'(bus.busy), 32'h0);
      stepClk();
      checkOutput("err_pulse_end", 32'(bus.err_valid), 32'h0);

      // Read command inside a write lock
      sendWord(0, 10'h0AA, "lockwr_addr");
      sendWord(0, 10'h2BB, "lockwr_bad");
      checkOutput("lockwr_err", 32'(bus.err_valid), 32'h1);
      checkOutput("lockwr_err_id", 32'(bus.err_id), 32'h0);
      checkOutput("lockwr_rxv", 32'(bus.ram_rx_valid), 32'h0);
      checkOutput("lockwr_busy", 32'(bus.busy), 32'h1);
      sendWord(0, 10'h155, "lockwr_data");
      checkOutput("lockwr_data_din", 32'(bus.ram_din), 32'h155);
      checkOutput("lockwr_data_busy", 32'(bus.busy), 32'h0);

      // Write command inside a read lock, then reset while waiting for ram
      sendWord(1, 10'h210, "lockrd_addr");
      sendWord(1, 10'h044, "lockrd_bad");
      checkOutput("lockrd_err", 32'(bus.err_valid), 32'h1);
      checkOutput("lockrd_err_id", 32'(bus.err_id), 32'h1);
      checkOutput("lockrd_owner", 32'(bus.owner_id), 32'h1);
      sendWord(1, 10'h3FF, "lockrd_data");
      checkOutput("lockrd_wait_busy", 32'(bus.busy), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_busy", 32'(bus.busy), 32'h0);
      checkOutput("arst_owner", 32'(bus.owner_id), 32'h0);
      checkOutput("arst_din", 32'(bus.ram_din), 32'h0);
      checkOutput("arst_rxv", 32'(bus.ram_rx_valid), 32'h0);
      checkOutput("arst_err", 32'(bus.err_valid), 32'h0);
      bus.ram_tx_data  = 8'hAB;
      bus.ram_tx_valid = 1'b1;
      #2;
      rst_n = 1'b1;
      stepClk();
      bus.ram_tx_valid = 1'b0;
      checkOutput("arst_no_rsp", 32'(bus.rsp_valid), 32'h0);
      sendWord(1, 10'h012, "post_rst_addr");
      checkOutput("post_rst_owner", 32'(bus.owner_id), 32'h1);
      checkOutput("post_rst_din_a", 32'(bus.ram_din), 32'h012);
      sendWord(1, 10'h134, "post_rst_data");
      checkOutput("post_rst_din_d", 32'(bus.ram_din), 32'h134);
      checkOutput("post_rst_busy", 32'(bus.busy), 32'h0);

`ifdef ARB_TIMEOUT_EN
      // Pointer is 0 after the last release; req0 locks, stalls, and req1 waits behind it.
      sendWord(0, 10'h010, "to_addr");
      applyStimulus(1, 10'h020);
      for (int c = 0; c < 63; c++) stepClk();
      checkOutput("to_still_busy", 32'(bus.busy), 32'h1);
      stepClk();
      checkOutput("to_busy", 32'(bus.busy), 32'h0);
      checkOutput("to_err", 32'(bus.err_valid), 32'h1);
      checkOutput("to_err_id", 32'(bus.err_id), 32'h0);
      checkOutput("to_next_grant", 32'(bus.req_ready), 32'h2);
      stepClk();
      checkOutput("to_req1_owner", 32'(bus.owner_id), 32'h1);
      sendWord(1, 10'h121, "to_req1_data");
      checkOutput("to_req1_din", 32'(bus.ram_din), 32'h121);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
